// File: rtl/text_console.sv
// Writer side of the 80x25 text video memory: byte stream in, char/attr
// cells, hardware scroll and clear out through the RAM's second port.
//
// state   | meaning
// IDLE    | waiting for a byte, in_ready high
// WCHAR   | writing the character byte of the current cell
// WATTR   | writing the attribute byte of the current cell
// ADVANCE | updating the cursor / dispatching control codes
// SCR_RD  | scroll: reading the byte one row below
// SCR_WR  | scroll: writing that byte one row up
// FILL    | writing FILL_CHAR/attr pairs (clear or last row after scroll)
module text_console #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 25,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_attr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic [7:0]  cursor_x,
  output logic [7:0]  cursor_y,
  output logic [12:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam logic [12:0] ROW_BYTES   = 13'(2 * COLS);
  localparam logic [12:0] SCREEN_LAST = 13'(2 * COLS * ROWS - 1);
  localparam logic [12:0] SCROLL_LAST = 13'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [7:0]  X_LAST      = 8'(COLS - 1);
  localparam logic [7:0]  Y_LAST      = 8'(ROWS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE, WCHAR, WATTR, ADVANCE, SCR_RD, SCR_WR, FILL
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  attr_q, attr_d;
  logic [12:0] idx_q, idx_d;

  logic [12:0] cell_idx;
  logic [12:0] cell_addr;

  // Character byte of the cell under the cursor; the attribute is the next byte.
  assign cell_idx  = {5'b0, x_q} + 13'(y_q) * 13'(COLS);
  assign cell_addr = {cell_idx[11:0], 1'b0};

  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;
  assign cursor_x = x_q;
  assign cursor_y = y_q;

  // State, cursor, latched byte/attribute and scroll/fill index registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      data_q  <= 8'd0;
      attr_q  <= 8'h07;
      idx_q   <= 13'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      attr_q  <= attr_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state, cursor arithmetic and RAM port drive.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    data_d      = data_q;
    attr_d      = attr_q;
    idx_d       = idx_q;
    mem_we      = 1'b0;
    mem_address = 13'd0;
    mem_wdata   = 8'd0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          attr_d  = in_attr;
          state_d = (in_data inside {CH_BS, CH_LF, CH_FF, CH_CR}) ? ADVANCE : WCHAR;
        end
      end
      WCHAR: begin
        mem_we      = 1'b1;
        mem_address = cell_addr;
        mem_wdata   = data_q;
        state_d     = WATTR;
      end
      WATTR: begin
        mem_we      = 1'b1;
        mem_address = {cell_idx[11:0], 1'b1};
        mem_wdata   = attr_q;
        state_d     = ADVANCE;
      end
      ADVANCE: begin
        state_d = IDLE;
        case (data_q)
          CH_CR: x_d = 8'd0;
          CH_BS: if (x_q != 8'd0) x_d = x_q - 8'd1;
          CH_LF: begin
            x_d = 8'd0;
            if (y_q == Y_LAST) begin
              state_d = SCR_RD;
              idx_d   = 13'd0;
            end else begin
              y_d = y_q + 8'd1;
            end
          end
          CH_FF: begin
            state_d = FILL;
            idx_d   = 13'd0;
          end
          default: begin
            if (x_q == X_LAST) begin
              x_d = 8'd0;
              // Cursor stays on the last row while the screen moves up.
              if (y_q == Y_LAST) begin
                state_d = SCR_RD;
                idx_d   = 13'd0;
              end else begin
                y_d = y_q + 8'd1;
              end
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        endcase
      end
      SCR_RD: begin
        mem_address = idx_q + ROW_BYTES;
        state_d     = SCR_WR;
      end
      SCR_WR: begin
        mem_we      = 1'b1;
        mem_address = idx_q;
        mem_wdata   = mem_rdata;
        idx_d       = idx_q + 13'd1;
        state_d     = (idx_q == SCROLL_LAST) ? FILL : SCR_RD;
      end
      FILL: begin
        mem_we      = 1'b1;
        mem_address = idx_q;
        mem_wdata   = idx_q[0] ? attr_q : FILL_CHAR;
        if (idx_q == SCREEN_LAST) begin
          state_d = IDLE;
          if (data_q == CH_FF) begin
            x_d = 8'd0;
            y_d = 8'd0;
          end
        end else begin
          idx_d = idx_q + 13'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: RAM model on the memory port, screen-level
// reference model of cursor and cell contents, randomised byte stream.
module tb_text_console;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [7:0]  in_data, in_attr;
  logic        in_valid;
  logic        in_ready, busy;
  logic [7:0]  cursor_x, cursor_y;
  logic [12:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  text_console dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .in_data(in_data), .in_attr(in_attr), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 CLOCK = ~CLOCK;

  // Text RAM with synchronous read, plus a log of every write.
  logic [7:0]  ram [8192] = '{default: 8'h00};
  int          wr_cnt = 0;
  int          bad_wr = 0;
  int unsigned la[$];
  logic [7:0]  ld[$];

  always @(posedge CLOCK) begin
    mem_rdata <= ram[mem_address];
    if (mem_we) begin
      ram[mem_address] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      la.push_back(32'(mem_address));
      ld.push_back(mem_wdata);
      if (mem_address >= 13'd4000) bad_wr <= bad_wr + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference screen: cells indexed y*80+x, cursor (mx,my).
  logic [7:0] m_ch [2000];
  logic [7:0] m_at [2000];
  int mx = 0, my = 0;

  function automatic void m_scroll(input logic [7:0] a);
    for (int i = 0; i < 1920; i++) begin
      m_ch[i] = m_ch[i+80];
      m_at[i] = m_at[i+80];
    end
    for (int i = 1920; i < 2000; i++) begin
      m_ch[i] = 8'h20;
      m_at[i] = a;
    end
  endfunction

  function automatic void m_step(input logic [7:0] d, input logic [7:0] a,
                                 output int cyc, output int wr);
    cyc = 1;
    wr  = 0;
    case (d)
      8'h0D: mx = 0;
      8'h08: if (mx > 0) mx--;
      8'h0A: begin
        mx = 0;
        if (my == 24) begin m_scroll(a); cyc += 7840; wr = 4000; end
        else my++;
      end
      8'h0C: begin
        for (int i = 0; i < 2000; i++) begin m_ch[i] = 8'h20; m_at[i] = a; end
        mx = 0; my = 0; cyc = 4001; wr = 4000;
      end
      default: begin
        m_ch[my*80+mx] = d;
        m_at[my*80+mx] = a;
        cyc = 3; wr = 2;
        mx++;
        if (mx == 80) begin
          mx = 0; my++;
          if (my == 25) begin m_scroll(a); my = 24; cyc += 7840; wr += 4000; end
        end
      end
    endcase
  endfunction

  function automatic int ram_diffs();
    int n = 0;
    for (int i = 0; i < 2000; i++)
      if (ram[2*i] !== m_ch[i] || ram[2*i+1] !== m_at[i]) n++;
    return n;
  endfunction

  // Send one byte (called #1 after a rising edge with the block idle),
  // jiggle in_valid while busy, then check cursor, busy length, write count.
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int cyc, wr0, ecyc, ewr;
    chk("ready_before", in_ready, 1);
    wr0 = wr_cnt;
    in_data = d; in_attr = a; in_valid = 1'b1;
    @(posedge CLOCK); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 9000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      in_attr  = 8'($urandom);
      @(posedge CLOCK); #1;
      cyc++;
    end
    in_valid = 1'b0;
    m_step(d, a, ecyc, ewr);
    chk("busy_cycles", cyc, ecyc);
    chk("writes", wr_cnt - wr0, ewr);
    chk("cursor_x", cursor_x, mx);
    chk("cursor_y", cursor_y, my);
  endtask

  initial begin
    int base;
    logic [7:0] d, old1, fa;
    for (int i = 0; i < 2000; i++) begin m_ch[i] = 8'h00; m_at[i] = 8'h00; end
    RESET = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_attr = 8'h00;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_x", cursor_x, 0);
    chk("rst_y", cursor_y, 0);
    RESET = 1'b0;
    @(posedge CLOCK); #1;

    // First character: exact write pair.
    base = la.size();
    send(8'h41, 8'h1F);
    chk("A_addr0", la[base], 0);
    chk("A_data0", ld[base], 8'h41);
    chk("A_addr1", la[base+1], 1);
    chk("A_data1", ld[base+1], 8'h1F);

    // Last column of row 3, then wrap.
    repeat (3) send(8'h0A, 8'h07);
    for (int i = 0; i < 79; i++) send(8'($urandom_range(8'h21, 8'h7E)), 8'($urandom));
    base = la.size();
    send(8'h5A, 8'h2E);
    chk("Z_addr0", la[base], 638);
    chk("Z_data0", ld[base], 8'h5A);
    chk("Z_addr1", la[base+1], 639);
    chk("Z_data1", ld[base+1], 8'h2E);

    // Control codes move the cursor only.
    send(8'h08, 8'h07);
    send(8'h41, 8'h07);
    send(8'h42, 8'h07);
    send(8'h08, 8'h07);
    send(8'h0D, 8'h07);

    // Clear, fill screen up to (79,24), then LF scrolls.
    send(8'h0C, 8'h1E);
    chk("clear_ram", ram_diffs(), 0);
    for (int i = 0; i < 1999; i++) send(8'($urandom_range(8'h21, 8'h7E)), 8'($urandom));
    old1 = m_ch[80];
    fa = 8'h5C;
    send(8'h0A, fa);
    chk("scroll_ram", ram_diffs(), 0);
    chk("scroll_row0", ram[0], old1);
    chk("scroll_fill_ch", ram[3840], 8'h20);
    chk("scroll_fill_at", ram[3999], fa);

    // Reset in the middle of a scroll.
    in_data = 8'h0A; in_attr = 8'h07; in_valid = 1'b1;
    @(posedge CLOCK); #1;
    in_valid = 1'b0;
    repeat (3000) @(posedge CLOCK);
    #3;
    chk("mid_busy_pre", busy, 1);
    RESET = 1'b1;
    #1;
    chk("mid_ready", in_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_we", mem_we, 0);
    chk("mid_addr", mem_address, 0);
    chk("mid_wdata", mem_wdata, 0);
    chk("mid_x", cursor_x, 0);
    chk("mid_y", cursor_y, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    mx = 0; my = 0;
    @(posedge CLOCK); #1;
    base = la.size();
    send(8'h51, 8'h4A);
    chk("post_rst_addr", la[base], 0);
    chk("post_rst_data", ld[base], 8'h51);

    // Clear with attr 07.
    send(8'h0C, 8'h07);
    chk("ff_ram", ram_diffs(), 0);
    chk("ff_3998", ram[3998], 8'h20);
    chk("ff_3999", ram[3999], 8'h07);

    // Random byte stream.
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       d = 8'h0A;
      else if (r < 16) d = 8'h08;
      else if (r < 22) d = 8'h0D;
      else begin
        d = 8'($urandom);
        if (d == 8'h0C) d = 8'h41;
      end
      send(d, 8'($urandom));
    end
    chk("random_ram", ram_diffs(), 0);
    chk("palette_writes", bad_wr, 0);
    chk("palette_4000", ram[4000], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
